// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states,
// instruction classes and the default pass-through ALU code.
package cpu_pkg;

    localparam logic [3:0] PASS_OP_DEFAULT = 4'h0;

    localparam logic [3:0] OPC_LDI  = 4'h8;
    localparam logic [3:0] OPC_LD   = 4'h9;
    localparam logic [3:0] OPC_ST   = 4'hA;
    localparam logic [3:0] OPC_JZ   = 4'hB;
    localparam logic [3:0] OPC_JMP  = 4'hC;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_IMM   = 3'd2,
        ST_MEMRD = 3'd3,
        ST_MEMWR = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LDI  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_JZ   = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_HALT = 3'd6,
        CLS_NOP  = 3'd7
    } iclass_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits IR into fields and classifies the opcode.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [15:0]       ir_i,
    output logic [3:0]        opc_o,
    output logic [3:0]        d_o,
    output logic [3:0]        a_o,
    output logic [3:0]        b_o,
    output logic [ADDR_W-1:0] tgt_o,
    output iclass_e           iclass_o
);

    assign opc_o = ir_i[15:12];
    assign d_o   = ir_i[11:8];
    assign a_o   = ir_i[7:4];
    assign b_o   = ir_i[3:0];
    assign tgt_o = ir_i[ADDR_W-1:0];

    // Map opcode to instruction class; 0x0-0x7 are ALU ops, 0xD-0xE are NOPs
    always_comb begin
        iclass_o = CLS_NOP;
        if (!ir_i[15]) begin
            iclass_o = CLS_ALU;
        end else begin
            case (ir_i[15:12])
                OPC_LDI:  iclass_o = CLS_LDI;
                OPC_LD:   iclass_o = CLS_LD;
                OPC_ST:   iclass_o = CLS_ST;
                OPC_JZ:   iclass_o = CLS_JZ;
                OPC_JMP:  iclass_o = CLS_JMP;
                OPC_HALT: iclass_o = CLS_HALT;
                default:  iclass_o = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions over a req/ack memory
// port and sequences the register-file datapath.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [3:0]  PASS_OP = PASS_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    input  logic [15:0]       A_OUT,
    input  logic [15:0]       B_OUT,
    input  logic              Z,
    output logic              data_sel,
    output logic [15:0]       const_in,
    output logic              const_sel,
    output logic              load_en,
    output logic [3:0]        dest_sel,
    output logic [3:0]        A_sel,
    output logic [3:0]        B_sel,
    output logic [3:0]        op_sel,
    output logic              halted
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic              z_q;

    logic [3:0]        opc, fd, fa, fb;
    logic [ADDR_W-1:0] tgt;
    iclass_e           iclass;

    logic unused_a_hi;
    assign unused_a_hi = ^A_OUT[15:ADDR_W];

    instr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .ir_i     (ir_q),
        .opc_o    (opc),
        .d_o      (fd),
        .a_o      (fa),
        .b_o      (fb),
        .tgt_o    (tgt),
        .iclass_o (iclass)
    );

    // FSM: state, PC, IR and zero flag; acks only matter in states that request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (iclass)
                        CLS_ALU: begin
                            z_q     <= Z;
                            state_q <= ST_FETCH;
                        end
                        CLS_LDI:  state_q <= ST_IMM;
                        CLS_LD:   state_q <= ST_MEMRD;
                        CLS_ST:   state_q <= ST_MEMWR;
                        CLS_JZ: begin
                            if (z_q) pc_q <= tgt;
                            state_q <= ST_FETCH;
                        end
                        CLS_JMP: begin
                            pc_q    <= tgt;
                            state_q <= ST_FETCH;
                        end
                        CLS_HALT: state_q <= ST_HALT;
                        default:  state_q <= ST_FETCH;
                    endcase
                end
                ST_IMM: begin
                    if (mem_ack) begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEMRD, ST_MEMWR: begin
                    if (mem_ack) state_q <= ST_FETCH;
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    // Datapath and memory controls; load_en in IMM/MEMRD is qualified by the ack
    // itself so a zero-wait ack completes in the cycle the request is raised
    always_comb begin
        mem_addr  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        data_sel  = 1'b0;
        const_in  = '0;
        const_sel = 1'b0;
        load_en   = 1'b0;
        dest_sel  = '0;
        A_sel     = '0;
        B_sel     = '0;
        op_sel    = '0;
        halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                ST_EXEC: begin
                    if (iclass == CLS_ALU) begin
                        A_sel    = fa;
                        B_sel    = fb;
                        op_sel   = opc;
                        dest_sel = fd;
                        load_en  = 1'b1;
                    end
                end
                ST_IMM: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ack) begin
                        const_in  = mem_rdata;
                        const_sel = 1'b1;
                        op_sel    = PASS_OP;
                        dest_sel  = fd;
                        load_en   = 1'b1;
                    end
                end
                ST_MEMRD: begin
                    A_sel    = fa;
                    mem_addr = A_OUT[ADDR_W-1:0];
                    mem_req  = 1'b1;
                    if (mem_ack) begin
                        data_sel = 1'b1;
                        dest_sel = fd;
                        load_en  = 1'b1;
                    end
                end
                ST_MEMWR: begin
                    A_sel     = fa;
                    B_sel     = fb;
                    mem_addr  = A_OUT[ADDR_W-1:0];
                    mem_wdata = B_OUT;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                end
                ST_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: the bench plays the memory
// and datapath, driving acks/read data by hand and checking every control output.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_req, mem_we;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] A_OUT, B_OUT;
    logic        Z;
    logic        data_sel, const_sel, load_en, halted;
    logic [15:0] const_in;
    logic [3:0]  dest_sel, A_sel, B_sel, op_sel;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit #(.ADDR_W(8), .PASS_OP(4'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .A_OUT     (A_OUT),
        .B_OUT     (B_OUT),
        .Z         (Z),
        .data_sel  (data_sel),
        .const_in  (const_in),
        .const_sel (const_sel),
        .load_en   (load_en),
        .dest_sel  (dest_sel),
        .A_sel     (A_sel),
        .B_sel     (B_sel),
        .op_sel    (op_sel),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [15:0] data);
        mem_ack   = ack;
        mem_rdata = data;
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        A_OUT = '0; B_OUT = '0; Z = 1'b0;
        step(); step();

        // Reset: all outputs forced low even with live inputs
        A_OUT = 16'hFFFF; B_OUT = 16'hFFFF;
        drive(1'b1, 16'hFFFF);
        chk("rst_req",      mem_req,   0);
        chk("rst_load",     load_en,   0);
        chk("rst_halted",   halted,    0);
        chk("rst_addr",     mem_addr,  0);
        chk("rst_wdata",    mem_wdata, 0);
        chk("rst_constsel", const_sel, 0);
        A_OUT = '0; B_OUT = '0;

        // ALU then HALT, zero-wait acks
        reset = 1'b0;
        drive(1'b0, 16'h0000);
        chk("f0_req",  mem_req,  1);
        chk("f0_addr", mem_addr, 8'h00);
        chk("f0_we",   mem_we,   0);
        drive(1'b1, 16'h1123);
        chk("f0_load", load_en, 0);
        step();
        drive(1'b0, 16'h0000);
        chk("alu_load", load_en,  1);
        chk("alu_dest", dest_sel, 1);
        chk("alu_A",    A_sel,    2);
        chk("alu_B",    B_sel,    3);
        chk("alu_op",   op_sel,   1);
        chk("alu_csel", const_sel, 0);
        chk("alu_dsel", data_sel, 0);
        chk("alu_req",  mem_req,  0);
        step();
        chk("f1_load", load_en,  0);
        chk("f1_addr", mem_addr, 8'h01);
        drive(1'b1, 16'hF000);
        step();
        drive(1'b0, 16'h0000);
        chk("hx_halted", halted,  0);
        chk("hx_load",   load_en, 0);
        step();
        chk("h4_halted", halted,  1);
        chk("h4_req",    mem_req, 0);
        drive(1'b1, 16'h1123);
        step();
        chk("h5_halted", halted,  1);
        chk("h5_req",    mem_req, 0);
        chk("h5_load",   load_en, 0);
        drive(1'b0, 16'h0000);
        step();
        chk("h6_halted", halted, 1);

        // Reset out of HALT, then LDI with one wait cycle on the immediate
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rh_halted", halted,   0);
        chk("rh_addr",   mem_addr, 8'h00);
        drive(1'b1, 16'h8500);
        step();
        drive(1'b0, 16'h0000);
        chk("ldi_ex_load", load_en, 0);
        chk("ldi_ex_req",  mem_req, 0);
        step();
        chk("imm_req",  mem_req,  1);
        chk("imm_addr", mem_addr, 8'h01);
        chk("imm_wait_load", load_en, 0);
        step();
        chk("imm_hold_addr", mem_addr, 8'h01);
        drive(1'b1, 16'hBEEF);
        chk("imm_cin",  const_in,  16'hBEEF);
        chk("imm_csel", const_sel, 1);
        chk("imm_dest", dest_sel,  5);
        chk("imm_op",   op_sel,    0);
        chk("imm_dsel", data_sel,  0);
        chk("imm_load", load_en,   1);
        step();
        drive(1'b0, 16'h0000);
        chk("ldi_pc2",   mem_addr,  8'h02);
        chk("ldi_after_csel", const_sel, 0);
        chk("ldi_after_load", load_en,   0);

        // LD r7 <- [r4], three wait cycles
        drive(1'b1, 16'h9740);
        step();
        A_OUT = 16'h0040;
        drive(1'b0, 16'h0000);
        chk("ld_ex_load", load_en, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_addr", mem_addr, 8'h40);
            chk("ld_wait_req",  mem_req,  1);
            chk("ld_wait_we",   mem_we,   0);
            chk("ld_wait_Asel", A_sel,    4);
            chk("ld_wait_load", load_en,  0);
            chk("ld_wait_dsel", data_sel, 0);
            step();
        end
        drive(1'b1, 16'h5555);
        chk("ld_ack_addr", mem_addr, 8'h40);
        chk("ld_ack_load", load_en,  1);
        chk("ld_ack_dsel", data_sel, 1);
        chk("ld_ack_dest", dest_sel, 7);
        step();
        drive(1'b0, 16'h0000);
        chk("ld_next_addr", mem_addr, 8'h03);
        chk("ld_next_load", load_en,  0);

        // ST [r1] <- r2
        drive(1'b1, 16'hA012);
        step();
        A_OUT = 16'h0010; B_OUT = 16'h1234;
        drive(1'b0, 16'h0000);
        step();
        chk("st_we",    mem_we,    1);
        chk("st_req",   mem_req,   1);
        chk("st_addr",  mem_addr,  8'h10);
        chk("st_wdata", mem_wdata, 16'h1234);
        chk("st_Asel",  A_sel,     1);
        chk("st_Bsel",  B_sel,     2);
        chk("st_load",  load_en,   0);
        drive(1'b1, 16'h0000);
        chk("st_ack_load", load_en, 0);
        step();
        drive(1'b0, 16'h0000);
        chk("st_next_addr", mem_addr, 8'h04);
        chk("st_next_we",   mem_we,   0);

        // ALU with Z=1, then JZ 0x20 taken
        drive(1'b1, 16'h0000);
        step();
        Z = 1'b1;
        drive(1'b0, 16'h0000);
        chk("z1_alu_load", load_en, 1);
        step();
        Z = 1'b0;
        drive(1'b0, 16'h0000);
        chk("jz1_fetch_addr", mem_addr, 8'h05);
        drive(1'b1, 16'hB020);
        step();
        drive(1'b0, 16'h0000);
        chk("jz1_ex_load", load_en, 0);
        chk("jz1_ex_req",  mem_req, 0);
        step();
        chk("jz_taken_addr", mem_addr, 8'h20);

        // ALU with Z=0, NOP with Z=1 (flag must not move), JZ not taken
        drive(1'b1, 16'h0000);
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("nop_fetch_addr", mem_addr, 8'h21);
        drive(1'b1, 16'hD000);
        step();
        Z = 1'b1;
        drive(1'b1, 16'h1111);
        chk("nop_load", load_en, 0);
        chk("nop_req",  mem_req, 0);
        step();
        Z = 1'b0;
        drive(1'b0, 16'h0000);
        chk("jz2_fetch_addr", mem_addr, 8'h22);
        drive(1'b1, 16'hB030);
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("jz_not_taken_addr", mem_addr, 8'h23);

        // JMP 0xFF, NOP at 0xFF, PC wraps to 0x00
        drive(1'b1, 16'hC0FF);
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("jmp_addr", mem_addr, 8'hFF);
        drive(1'b1, 16'hD000);
        step();
        drive(1'b0, 16'h0000);
        step();
        chk("wrap_addr", mem_addr, 8'h00);

        // Reset during MEMRD wait with an ack in the reset cycle
        drive(1'b1, 16'h9740);
        step();
        A_OUT = 16'h0040;
        drive(1'b0, 16'h0000);
        step();
        chk("rld_addr", mem_addr, 8'h40);
        chk("rld_req",  mem_req,  1);
        step();
        reset = 1'b1;
        drive(1'b1, 16'h5555);
        chk("rld_rst_load", load_en,  0);
        chk("rld_rst_req",  mem_req,  0);
        chk("rld_rst_dsel", data_sel, 0);
        step();
        reset = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rld_post_req",  mem_req,  1);
        chk("rld_post_addr", mem_addr, 8'h00);
        chk("rld_post_load", load_en,  0);
        chk("rld_post_we",   mem_we,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter ADDR_W, default 8: program counter and memory address width.
REQ-002 Parameter PASS_OP, default 4'h0: the func_unit op_sel code that drives its B operand unchanged to the output.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mem_addr, output, ADDR_W: memory address.
REQ-006 Port mem_req, output, 1: memory request, held until acknowledged.
REQ-007 Port mem_we, output, 1: write qualifier for mem_req.
REQ-008 Port mem_wdata, output, 16: store data.
REQ-009 Port mem_rdata, input, 16: read data, valid when mem_ack=1.
REQ-010 Port mem_ack, input, 1: single-cycle completion pulse.
REQ-011 Ports A_OUT and B_OUT, input, 16 each: datapath register-file read ports.
REQ-012 Port Z, input, 1: func_unit zero flag.
REQ-013 Outputs to the datapath: data_sel (1), const_in (16), const_sel (1), load_en (1), dest_sel (4), A_sel (4), B_sel (4), op_sel (4).
REQ-014 Port halted, output, 1: high while in HALT.

Function
REQ-015 Instruction format SHALL be: opc = IR[15:12], d = IR[11:8], a = IR[7:4], b = IR[3:0], tgt = IR[ADDR_W-1:0].
REQ-016 Opcodes SHALL be: 0x0-0x7 ALU; 0x8 LDI (two words); 0x9 LD; 0xA ST; 0xB JZ; 0xC JMP; 0xF HALT; 0xD-0xE NOP.
REQ-017 The FSM SHALL have these states: FETCH, EXEC, IMM, MEMRD, MEMWR, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, IR<=mem_rdata, PC<=PC+1 (wraps from all-ones to 0), next state EXEC.
REQ-019 EXEC ALU: A_sel=a, B_sel=b, op_sel=opc, const_sel=0, data_sel=0, dest_sel=d, load_en=1 for exactly one cycle; z_flag<=Z; next state FETCH.
REQ-020 EXEC LDI: next state IMM. IMM: fetch the word at PC. On mem_ack: const_in=mem_rdata, const_sel=1, op_sel=PASS_OP, data_sel=0, dest_sel=d, load_en=1 in the ack cycle; PC+1; next state FETCH.
REQ-021 EXEC LD: next state MEMRD. MEMRD: A_sel=a, mem_addr=A_OUT[ADDR_W-1:0], mem_req=1. On mem_ack: data_sel=1, dest_sel=d, load_en=1; next state FETCH.
REQ-022 EXEC ST: next state MEMWR. MEMWR: A_sel=a, B_sel=b, mem_addr=A_OUT[ADDR_W-1:0], mem_wdata=B_OUT, mem_req=1, mem_we=1. On mem_ack: next state FETCH; no register write.
REQ-023 EXEC JZ: PC<=tgt if z_flag=1, else PC unchanged. EXEC JMP: PC<=tgt. Both SHALL go to FETCH.
REQ-024 EXEC HALT SHALL enter HALT; HALT is held, with halted=1 and mem_req=0, until reset.
REQ-025 NOP SHALL return to FETCH with no side effects.
REQ-026 load_en SHALL be 0 in every cycle not named in REQ-019, REQ-020 and REQ-021.
REQ-027 mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1 and no mem_ack has arrived; wait states are unbounded.
REQ-028 mem_ack arriving in the same cycle mem_req rises SHALL be accepted (zero wait). Minimum latency per class: ALU, jump and NOP 2 cycles; LDI, LD and ST 3 cycles.
REQ-029 mem_ack while mem_req=0 SHALL be ignored.
REQ-030 z_flag SHALL change only on ALU execute cycles.

Reset
REQ-031 When reset=1 at a clock edge: state=FETCH, PC=0, IR=0, z_flag=0.
REQ-032 While reset=1: every output is 0, including mem_req, load_en and halted.
REQ-033 Reset SHALL override an outstanding transaction; an ack in the reset cycle is ignored; fetch from address 0 starts in the first cycle after reset deasserts.

Structure
REQ-034 Opcode constants, state encodings and PASS_OP default SHALL live in a shared package, cpu_pkg.
REQ-035 One sub-module is natural: instr_decode (combinational: IR to datapath select fields and instruction class).

Verification
REQ-036 ALU, zero-wait ack: program {0x1123, 0xF000} -> load_en high one cycle with dest_sel=1, A_sel=2, B_sel=3, op_sel=1; then halted=1 from cycle 4 onward.
REQ-037 LDI: program {0x8500, 0xBEEF} -> const_in=0xBEEF, const_sel=1, dest_sel=5 in the ack cycle; PC=2 afterwards.
REQ-038 LD with 3 wait cycles, A_OUT=0x0040 -> mem_addr=0x40 held 4 cycles; load_en and data_sel high only in the ack cycle.
REQ-039 ST, A_OUT=0x0010, B_OUT=0x1234 -> mem_we=1, mem_addr=0x10, mem_wdata=0x1234; load_en stays 0.
REQ-040 JZ: Z=1 on the preceding ALU op, JZ 0x20 -> next fetch address 0x20; repeat with Z=0 -> next fetch address is the JZ address+1; PC at 0xFF with a non-jump -> next fetch at 0x00.
REQ-041 Reset asserted during a MEMRD wait, with ack in the reset cycle -> no load_en; mem_addr=0 with mem_req=1 in the first cycle after release.
